pwm_seq_ctrl: RTL and testbench

Sequencer for the down-counting PWM generator. It owns the generator's `cnt_en`, `counter_arr` and `counter_ccr` inputs and steps through a programmable table of (period, duty, repeat) entries. Updates land only on period boundaries, so no PWM period is ever truncated or mixed. It sits between the register/config bus and one PWM generator instance.

---
 rtl/pwm_seq_pkg.sv | 30 +++
 rtl/pwm_seq_table.sv | 31 +++
 rtl/pwm_seq_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_pwm_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM sequencer.
package pwm_seq_pkg;

    localparam int unsigned DEPTH_DEF = 8;
    localparam logic [31:0] ARR_MIN   = 32'd1;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RUN,
        LAST,
        DRAIN
    } seq_state_e;

    typedef struct packed {
        logic [31:0] arr;
        logic [31:0] ccr;
        logic [7:0]  reps;
    } seq_entry_t;

    // Clamp arr so an mc=1 update point always exists; reps of 0 means one period.
    function automatic seq_entry_t sanitize_entry(input seq_entry_t e);
        seq_entry_t r;
        r = e;
        if (e.arr < ARR_MIN) r.arr = ARR_MIN;
        if (e.reps == 8'd0)  r.reps = 8'd1;
        return r;
    endfunction

endpackage

// File: rtl/pwm_seq_table.sv
// Sequencer entry table: one synchronous write port, one combinational read
// port, contents not reset.
module pwm_seq_table
    import pwm_seq_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          Clk50M,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  seq_entry_t    wdata,
    input  logic [AW-1:0] raddr,
    output seq_entry_t    rdata
);

    seq_entry_t mem_q [DEPTH];

    // Table write port.
    always_ff @(posedge Clk50M) begin
        if (we) mem_q[waddr] <= wdata;
    end

    // Read port forwards a same-cycle write so a write in the update-point
    // cycle still reaches the entry being loaded at that edge.
    always_comb begin
        rdata = mem_q[raddr];
        if (we && (waddr == raddr)) rdata = wdata;
    end

endmodule

// File: rtl/pwm_seq_ctrl.sv
// PWM sequencer: steps the down-counting generator through a table of
// (period, duty, repeat) entries, changing values only on period boundaries.
// Optional feature macro: PWM_SEQ_LOOP_EN (honour loop_en).
module pwm_seq_ctrl
    import pwm_seq_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          Clk50M,
    input  logic          Rst_n,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [31:0]   cfg_arr,
    input  logic [31:0]   cfg_ccr,
    input  logic [7:0]    cfg_reps,
    input  logic [AW:0]   seq_len,
    input  logic          loop_en,
    input  logic          start,
    input  logic          stop,
    output logic          cnt_en,
    output logic [31:0]   counter_arr,
    output logic [31:0]   counter_ccr,
    output logic          busy,
    output logic [AW-1:0] cur_idx,
    output logic          period_tick,
    output logic          seq_done,
    output logic          aborted
);

    seq_state_e    state_q, state_d;
    logic [31:0]   mc_q, mc_d;
    logic [7:0]    rc_q, rc_d;
    logic [AW-1:0] cur_idx_q, cur_idx_d;
    logic [AW:0]   len_q, len_d;
    logic          cnt_en_q, cnt_en_d;
    logic [31:0]   arr_q, arr_d;
    logic [31:0]   ccr_q, ccr_d;
    logic          aborted_q, aborted_d;
    logic          seq_done_q, seq_done_d;

    logic          loop_on;
    logic          upd_pt;
    logic          at_zero;
    logic          is_last;
    logic [AW:0]   len_sampled;
    logic [AW-1:0] rd_addr;
    seq_entry_t    wr_entry;
    seq_entry_t    rd_raw;
    seq_entry_t    rd_entry;

`ifdef PWM_SEQ_LOOP_EN
    assign loop_on = loop_en;
`else
    logic unused_loop_en;
    assign unused_loop_en = loop_en;
    assign loop_on        = 1'b0;
`endif

    assign wr_entry = '{arr: cfg_arr, ccr: cfg_ccr, reps: cfg_reps};

    pwm_seq_table #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .Clk50M (Clk50M),
        .we     (cfg_we),
        .waddr  (cfg_addr),
        .wdata  (wr_entry),
        .raddr  (rd_addr),
        .rdata  (rd_raw)
    );

    assign rd_entry = sanitize_entry(rd_raw);
    assign upd_pt   = cnt_en_q && (mc_q == 32'd1);
    assign at_zero  = cnt_en_q && (mc_q == 32'd0);
    assign is_last  = ({1'b0, cur_idx_q} == (len_q - {{AW{1'b0}}, 1'b1}));

    // Sampled sequence length, clamped into 1..DEPTH.
    always_comb begin
        len_sampled = seq_len;
        if (seq_len == '0) len_sampled = {{AW{1'b0}}, 1'b1};
        else if (seq_len > (AW+1)'(DEPTH)) len_sampled = (AW+1)'(DEPTH);
    end

    // Address of the entry that would load next.
    always_comb begin
        rd_addr = cur_idx_q + AW'(1);
        if ((state_q == IDLE) || is_last) rd_addr = '0;
    end

    // Mirror of the generator's down counter.
    always_comb begin
        mc_d = mc_q - 32'd1;
        if (!cnt_en_q || (mc_q == 32'd0)) mc_d = arr_q;
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        rc_d       = rc_q;
        cur_idx_d  = cur_idx_q;
        len_d      = len_q;
        cnt_en_d   = cnt_en_q;
        arr_d      = arr_q;
        ccr_d      = ccr_q;
        aborted_d  = aborted_q;
        seq_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_en_d = 1'b0;
                if (start) begin
                    arr_d     = rd_entry.arr;
                    ccr_d     = rd_entry.ccr;
                    rc_d      = rd_entry.reps;
                    cur_idx_d = '0;
                    len_d     = len_sampled;
                    aborted_d = 1'b0;
                    state_d   = PRIME;
                end
            end
            PRIME: begin
                if (stop) begin
                    aborted_d = 1'b1;
                    state_d   = DRAIN;
                end else begin
                    cnt_en_d = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    aborted_d = 1'b1;
                    state_d   = DRAIN;
                end else if (upd_pt) begin
                    if (rc_q > 8'd1) begin
                        rc_d = rc_q - 8'd1;
                    end else if (!is_last || loop_on) begin
                        arr_d     = rd_entry.arr;
                        ccr_d     = rd_entry.ccr;
                        rc_d      = rd_entry.reps;
                        cur_idx_d = rd_addr;
                    end else begin
                        state_d = LAST;
                    end
                end
            end
            LAST: begin
                if (at_zero) begin
                    cnt_en_d   = 1'b0;
                    seq_done_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            DRAIN: begin
                // A stop during PRIME never enabled the generator: nothing to drain.
                if (at_zero || !cnt_en_q) begin
                    cnt_en_d   = 1'b0;
                    seq_done_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                cnt_en_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clk50M or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            mc_q       <= '0;
            rc_q       <= '0;
            cur_idx_q  <= '0;
            len_q      <= '0;
            cnt_en_q   <= 1'b0;
            arr_q      <= '0;
            ccr_q      <= '0;
            aborted_q  <= 1'b0;
            seq_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mc_q       <= mc_d;
            rc_q       <= rc_d;
            cur_idx_q  <= cur_idx_d;
            len_q      <= len_d;
            cnt_en_q   <= cnt_en_d;
            arr_q      <= arr_d;
            ccr_q      <= ccr_d;
            aborted_q  <= aborted_d;
            seq_done_q <= seq_done_d;
        end
    end

    assign cnt_en      = cnt_en_q;
    assign counter_arr = arr_q;
    assign counter_ccr = ccr_q;
    assign busy        = (state_q != IDLE);
    assign cur_idx     = cur_idx_q;
    assign period_tick = at_zero;
    assign seq_done    = seq_done_q;
    assign aborted     = aborted_q;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Directed self-checking bench for pwm_seq_ctrl with a behavioural model of
// the downstream PWM generator.
module tb_pwm_seq_ctrl;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic          Clk50M;
    logic          Rst_n;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [31:0]   cfg_arr;
    logic [31:0]   cfg_ccr;
    logic [7:0]    cfg_reps;
    logic [AW:0]   seq_len;
    logic          loop_en;
    logic          start;
    logic          stop;
    logic          cnt_en;
    logic [31:0]   counter_arr;
    logic [31:0]   counter_ccr;
    logic          busy;
    logic [AW-1:0] cur_idx;
    logic          period_tick;
    logic          seq_done;
    logic          aborted;

    int checks = 0;
    int errors = 0;

    pwm_seq_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .Clk50M      (Clk50M),
        .Rst_n       (Rst_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_arr     (cfg_arr),
        .cfg_ccr     (cfg_ccr),
        .cfg_reps    (cfg_reps),
        .seq_len     (seq_len),
        .loop_en     (loop_en),
        .start       (start),
        .stop        (stop),
        .cnt_en      (cnt_en),
        .counter_arr (counter_arr),
        .counter_ccr (counter_ccr),
        .busy        (busy),
        .cur_idx     (cur_idx),
        .period_tick (period_tick),
        .seq_done    (seq_done),
        .aborted     (aborted)
    );

    initial begin
        Clk50M = 1'b0;
        forever #10 Clk50M = ~Clk50M;
    end

    // Downstream generator model: loads arr when disabled or at zero.
    logic [31:0] gen_cnt;
    logic        pwm_out;
    always_ff @(posedge Clk50M or negedge Rst_n) begin
        if (!Rst_n)                            gen_cnt <= '0;
        else if (!cnt_en || gen_cnt == 32'd0)  gen_cnt <= counter_arr;
        else                                   gen_cnt <= gen_cnt - 32'd1;
    end
    assign pwm_out = cnt_en && (gen_cnt < counter_ccr);

    task automatic write_entry(input int addr, input int arr, input int ccr, input int reps);
        @(negedge Clk50M);
        cfg_we   = 1'b1;
        cfg_addr = AW'(addr);
        cfg_arr  = 32'(arr);
        cfg_ccr  = 32'(ccr);
        cfg_reps = 8'(reps);
        @(negedge Clk50M);
        cfg_we   = 1'b0;
    endtask

    task automatic pulse_start(input int len);
        @(negedge Clk50M);
        seq_len = (AW+1)'(len);
        start   = 1'b1;
        @(negedge Clk50M);
        start   = 1'b0;
    endtask

    // Observes one sequence from the PRIME cycle (index 0) until seq_done.
    task automatic measure(input int stop_at, input int wr_at, input int wa, input int warr,
                           input int wccr, input int wreps,
                           output int n_en, output int n_tick, output int n_hi,
                           output int first_en, output int last_en, output int arr_chg,
                           output int done_at, output logic ab, output logic en_at_done);
        logic [31:0] arr0;
        n_en = 0; n_tick = 0; n_hi = 0; first_en = -1; last_en = -1;
        arr_chg = -1; done_at = -1; ab = 1'b0; en_at_done = 1'b1; arr0 = '0;
        for (int c = 0; c < 400; c++) begin
            if (cnt_en) begin
                n_en++;
                if (first_en < 0) begin first_en = c; arr0 = counter_arr; end
                last_en = c;
                if (arr_chg < 0 && counter_arr !== arr0) arr_chg = c;
            end
            if (period_tick) n_tick++;
            if (pwm_out) n_hi++;
            if (seq_done) begin
                done_at = c; ab = aborted; en_at_done = cnt_en;
                break;
            end
            stop   = (c == stop_at);
            cfg_we = (c == wr_at);
            if (c == wr_at) begin
                cfg_addr = AW'(wa); cfg_arr = 32'(warr); cfg_ccr = 32'(wccr); cfg_reps = 8'(wreps);
            end
            @(negedge Clk50M);
        end
        stop   = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        #25;
        checks++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL reset_cnt_en got %b want 0", cnt_en); end
        checks++; if (counter_arr !== 32'd0 || counter_ccr !== 32'd0) begin errors++; $display("FAIL reset_arr_ccr got %0d/%0d want 0/0", counter_arr, counter_ccr); end
        checks++; if ({busy, cur_idx, period_tick, seq_done, aborted} !== '0) begin errors++; $display("FAIL reset_status got %b want 0", {busy, cur_idx, period_tick, seq_done, aborted}); end
        @(negedge Clk50M);
        Rst_n = 1'b1;
        @(negedge Clk50M);
    endtask

    task automatic test_single();
        int n_en, n_tick, n_hi, f, l, ch, d; logic ab, ed;
        write_entry(0, 9, 3, 2);
        pulse_start(1);
        checks++; if (busy !== 1'b1 || cnt_en !== 1'b0) begin errors++; $display("FAIL single_prime got busy=%b en=%b want 1/0", busy, cnt_en); end
        measure(-1, -1, 0, 0, 0, 0, n_en, n_tick, n_hi, f, l, ch, d, ab, ed);
        checks++; if (f !== 1) begin errors++; $display("FAIL single_latency got %0d want 1", f); end
        checks++; if (n_en !== 20) begin errors++; $display("FAIL single_en_cycles got %0d want 20", n_en); end
        checks++; if (n_hi !== 6) begin errors++; $display("FAIL single_pwm_high got %0d want 6", n_hi); end
        checks++; if (n_tick !== 2) begin errors++; $display("FAIL single_ticks got %0d want 2", n_tick); end
        checks++; if (d !== 21 || ed !== 1'b0) begin errors++; $display("FAIL single_done got at=%0d en=%b want 21/0", d, ed); end
        checks++; if (ab !== 1'b0) begin errors++; $display("FAIL single_aborted got %b want 0", ab); end
        @(negedge Clk50M);
        checks++; if (busy !== 1'b0 || seq_done !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b done=%b want 0/0", busy, seq_done); end
    endtask

    task automatic test_two_entries();
        int n_en, n_tick, n_hi, f, l, ch, d; logic ab, ed;
        write_entry(0, 4, 2, 1);
        write_entry(1, 7, 6, 1);
`ifdef PWM_SEQ_LOOP_EN
        loop_en = 1'b0;
`else
        loop_en = 1'b1;
`endif
        pulse_start(2);
        measure(-1, -1, 0, 0, 0, 0, n_en, n_tick, n_hi, f, l, ch, d, ab, ed);
        loop_en = 1'b0;
        checks++; if (n_en !== 13 || (l - f + 1) !== 13) begin errors++; $display("FAIL two_en_cycles got %0d span %0d want 13", n_en, l - f + 1); end
        checks++; if (ch !== 5) begin errors++; $display("FAIL two_arr_change got %0d want 5", ch); end
        checks++; if (n_hi !== 8 || n_tick !== 2) begin errors++; $display("FAIL two_hi_ticks got %0d/%0d want 8/2", n_hi, n_tick); end
        checks++; if (counter_arr !== 32'd7 || cur_idx !== 3'd1) begin errors++; $display("FAIL two_final got arr=%0d idx=%0d want 7/1", counter_arr, cur_idx); end
        checks++; if (d !== 14 || ab !== 1'b0) begin errors++; $display("FAIL two_done got at=%0d ab=%b want 14/0", d, ab); end
    endtask

    task automatic test_stop();
        int n_en, n_tick, n_hi, f, l, ch, d; logic ab, ed;
        write_entry(0, 4, 2, 1);
        write_entry(1, 7, 6, 3);
        pulse_start(2);
        measure(8, -1, 0, 0, 0, 0, n_en, n_tick, n_hi, f, l, ch, d, ab, ed);
        checks++; if (n_en !== 13) begin errors++; $display("FAIL stop_en_cycles got %0d want 13", n_en); end
        checks++; if (d !== 14 || ab !== 1'b1) begin errors++; $display("FAIL stop_done got at=%0d ab=%b want 14/1", d, ab); end
        repeat (3) @(negedge Clk50M);
        checks++; if (aborted !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL stop_hold got ab=%b busy=%b want 1/0", aborted, busy); end
        pulse_start(1);
        checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL stop_clear got %b want 0", aborted); end
        measure(-1, -1, 0, 0, 0, 0, n_en, n_tick, n_hi, f, l, ch, d, ab, ed);
    endtask

`ifdef PWM_SEQ_LOOP_EN
    task automatic test_loop();
        int n_en, n_tick, n_hi, f, l, ch, d; logic ab, ed;
        write_entry(0, 4, 2, 1);
        write_entry(1, 7, 6, 1);
        loop_en = 1'b1;
        pulse_start(2);
        measure(8, -1, 0, 0, 0, 0, n_en, n_tick, n_hi, f, l, ch, d, ab, ed);
        checks++; if (n_en !== 13 || ab !== 1'b1) begin errors++; $display("FAIL loop_stop got en=%0d ab=%b want 13/1", n_en, ab); end
        checks++; if (counter_arr !== 32'd7) begin errors++; $display("FAIL loop_no_reload got arr=%0d want 7", counter_arr); end
        pulse_start(2);
        measure(15, -1, 0, 0, 0, 0, n_en, n_tick, n_hi, f, l, ch, d, ab, ed);
        checks++; if (n_en !== 18 || counter_arr !== 32'd4) begin errors++; $display("FAIL loop_wrap got en=%0d arr=%0d want 18/4", n_en, counter_arr); end
        loop_en = 1'b0;
    endtask
`endif

    task automatic test_clamp();
        int n_en, n_tick, n_hi, f, l, ch, d; logic ab, ed;
        write_entry(0, 0, 0, 0);
        pulse_start(0);
        checks++; if (counter_arr !== 32'd1) begin errors++; $display("FAIL clamp_arr got %0d want 1", counter_arr); end
        measure(-1, -1, 0, 0, 0, 0, n_en, n_tick, n_hi, f, l, ch, d, ab, ed);
        checks++; if (n_en !== 2 || n_tick !== 1 || n_hi !== 0) begin errors++; $display("FAIL clamp_run got en=%0d tick=%0d hi=%0d want 2/1/0", n_en, n_tick, n_hi); end
        checks++; if (d !== 3) begin errors++; $display("FAIL clamp_done got %0d want 3", d); end
    endtask

    task automatic test_reset_mid_run();
        int n_en, n_tick, n_hi, f, l, ch, d; logic ab, ed;
        write_entry(0, 9, 3, 2);
        pulse_start(1);
        repeat (5) @(negedge Clk50M);
        Rst_n = 1'b0;
        #1;
        checks++; if ({cnt_en, busy} !== 2'b00 || counter_arr !== 32'd0 || counter_ccr !== 32'd0) begin errors++; $display("FAIL midrst got en=%b busy=%b arr=%0d ccr=%0d want 0", cnt_en, busy, counter_arr, counter_ccr); end
        @(negedge Clk50M);
        Rst_n = 1'b1;
        pulse_start(1);
        measure(-1, -1, 0, 0, 0, 0, n_en, n_tick, n_hi, f, l, ch, d, ab, ed);
        checks++; if (n_en !== 20 || n_hi !== 6 || d !== 21) begin errors++; $display("FAIL midrst_rerun got en=%0d hi=%0d done=%0d want 20/6/21", n_en, n_hi, d); end
    endtask

    task automatic test_late_write();
        int n_en, n_tick, n_hi, f, l, ch, d; logic ab, ed;
        write_entry(0, 4, 2, 2);
        write_entry(1, 3, 1, 1);
        pulse_start(2);
        // Entry 0 update points fall in cycles 4 and 9; rewrite entry 1 in cycle 9.
        measure(-1, 9, 1, 5, 2, 1, n_en, n_tick, n_hi, f, l, ch, d, ab, ed);
        checks++; if (n_en !== 16 || n_tick !== 3) begin errors++; $display("FAIL latewr_run got en=%0d tick=%0d want 16/3", n_en, n_tick); end
        checks++; if (ch !== 10 || counter_arr !== 32'd5 || counter_ccr !== 32'd2) begin errors++; $display("FAIL latewr_vals got chg=%0d arr=%0d ccr=%0d want 10/5/2", ch, counter_arr, counter_ccr); end
        checks++; if (n_hi !== 6) begin errors++; $display("FAIL latewr_hi got %0d want 6", n_hi); end
    endtask

    initial begin
        Rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_arr = '0; cfg_ccr = '0; cfg_reps = '0;
        seq_len = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
        test_reset();
        test_single();
        test_two_entries();
        test_stop();
`ifdef PWM_SEQ_LOOP_EN
        test_loop();
`endif
        test_clamp();
        test_reset_mid_run();
        test_late_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
